rsa_decoder: RTL

Receive-side counterpart of the RSA encoder (controller/datapath pair). Takes a 16-bit ciphertext word and recovers the 8-bit plaintext by modular exponentiation, m = c^D mod N, using a right-to-left square-and-multiply loop. It uses the same `input_data_ready`/`done` handshake as the encoder, so encoder `output_data` can feed decoder `cipher_data` directly for loopback checking.

---
 rtl/rsa_decoder_if.sv | 36 +++
 rtl/rsa_decoder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rsa_decoder_if.sv
// -----------------------------------------------------------------------------
// rsa_decoder_if
// Start/done handshake bundle between a ciphertext source (master) and the
// RSA decoder (slave). Field names match the encoder's handshake, so encoder
// output can drive cipher_data directly in loopback.
// -----------------------------------------------------------------------------
`default_nettype none

interface rsa_decoder_if;
    logic [15:0] cipher_data;
    logic        input_data_ready;
    logic        busy;
    logic        done;
    logic [7:0]  output_data;
    logic        error;

    modport master (
        output cipher_data,
        output input_data_ready,
        input  busy,
        input  done,
        input  output_data,
        input  error
    );

    modport slave (
        input  cipher_data,
        input  input_data_ready,
        output busy,
        output done,
        output output_data,
        output error
    );
endinterface

`default_nettype wire

// File: rtl/rsa_decoder.sv
// -----------------------------------------------------------------------------
// rsa_decoder
// Recovers an 8-bit plaintext from a 16-bit ciphertext, m = c^D mod N, with a
// right-to-left square-and-multiply loop: one MUL and one MOD cycle per
// exponent bit, so latency is fixed regardless of data or exponent value.
// Optional feature macro: RSA_DEC_RANGE_CHECK_EN (reject c >= N with error=1).
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rsa_decoder #(
    parameter int unsigned MOD_N = 3233,
    parameter int unsigned EXP_D = 2753,
    parameter int unsigned EXP_W = 12
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    rsa_decoder_if.slave bus
);

    localparam int unsigned IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [EXP_W-1:0] EXP_BITS = EXP_D[EXP_W-1:0];
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(EXP_W - 1);
    localparam logic [31:0]      MOD_N32  = 32'(MOD_N);
`ifdef RSA_DEC_RANGE_CHECK_EN
    localparam logic [15:0]      MOD_N16  = 16'(MOD_N);
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        MOD  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t           state;
    logic [15:0]      c_reg;
    logic [15:0]      base;
    logic [15:0]      result;
    logic [IDX_W-1:0] bit_idx;
    logic [31:0]      sq;
    logic [31:0]      pr;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       data_q;

    // Both remainders are < N < 2^16, so the 16-bit truncation is lossless.
    logic [15:0] base_next;
    logic [15:0] result_next;
    assign base_next   = 16'(sq % MOD_N32);
    assign result_next = 16'(pr % MOD_N32);

`ifdef RSA_DEC_RANGE_CHECK_EN
    logic error_q;
`endif

    // Controller and datapath: one state step per clock, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            c_reg   <= '0;
            base    <= '0;
            result  <= '0;
            bit_idx <= '0;
            sq      <= '0;
            pr      <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 8'h00;
`ifdef RSA_DEC_RANGE_CHECK_EN
            error_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.input_data_ready) begin
                        c_reg  <= bus.cipher_data;
                        busy_q <= 1'b1;
`ifdef RSA_DEC_RANGE_CHECK_EN
                        if (bus.cipher_data >= MOD_N16) begin
                            // Out-of-range ciphertext skips the exponentiation.
                            state   <= FIN;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                            data_q  <= 8'h00;
                        end else begin
                            state <= LOAD;
                        end
`else
                        state <= LOAD;
`endif
                    end
                end
                LOAD: begin
                    base    <= c_reg;
                    result  <= 16'd1;
                    bit_idx <= '0;
`ifdef RSA_DEC_RANGE_CHECK_EN
                    error_q <= 1'b0;
`endif
                    state   <= MUL;
                end
                MUL: begin
                    sq <= {16'h0000, base} * {16'h0000, base};
                    if (EXP_BITS[bit_idx])
                        pr <= {16'h0000, result} * {16'h0000, base};
                    else
                        pr <= {16'h0000, result};
                    state <= MOD;
                end
                MOD: begin
                    base   <= base_next;
                    result <= result_next;
                    if (bit_idx == LAST_IDX) begin
                        // Output captures the final remainder on the FIN entry edge.
                        state  <= FIN;
                        done_q <= 1'b1;
                        data_q <= result_next[7:0];
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        state   <= MUL;
                    end
                end
                FIN: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.output_data = data_q;
`ifdef RSA_DEC_RANGE_CHECK_EN
    assign bus.error       = error_q;
`else
    assign bus.error       = 1'b0;
`endif

endmodule

`default_nettype wire
